prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/types_pkg.sv | 21 ++
 rtl/loader_checksum.sv | 27 ++
 rtl/prog_loader.sv | 175 +++++++++++++++++
 tb/tb_prog_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared state encoding and constants for the program loader
// Build option: LOADER_CHECKSUM_EN adds the CHECK state (trailing checksum byte).
package types_pkg;

   // Bytes in the stream header (word count, high byte first)
   localparam int unsigned HDR_LEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN_HI  = 3'd1,
      ST_LEN_LO  = 3'd2,
      ST_DATA_HI = 3'd3,
      ST_DATA_LO = 3'd4,
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK   = 3'd5,
`endif
      ST_DONE    = 3'd6,
      ST_ERROR   = 3'd7
   } loader_state_e;

endpackage

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - 8-bit XOR accumulator over accepted stream bytes
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clr         synchronous clear (new load starting)
//   byte_valid  fold byte_data into the sum this cycle
//   byte_data   stream byte
//   sum         running XOR of all folded bytes
module loader_checksum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic [7:0] sum
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= 8'h00;
      end else if (clr) begin
         sum <= 8'h00;
      end else if (byte_valid) begin
         sum <= sum ^ byte_data;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing 16-bit words to program memory
// Build option: LOADER_CHECKSUM_EN - stream ends with an XOR checksum byte that is verified.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle load request (ignored while busy)
//   in_valid/in_data/in_ready  byte stream handshake
//   pm_we/pm_addr/pm_wdata     program-memory write port
//   cpu_hold        keeps the CPU in reset during a load and after a failed load
//   busy/done/error load status (done/error sticky until the next start)
//   words_loaded    words written in the current or last load
module prog_loader
   import types_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              pm_we,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [15:0]       pm_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   loader_state_e   state;
   logic [7:0]      len_hi;
   logic [7:0]      data_hi;
   logic [15:0]     len;
   logic [15:0]     n_word;
   logic [ADDR_W:0] wl_next;
   logic            accept;

   assign accept  = in_valid && in_ready;
   assign n_word  = {len_hi, in_data};
   assign wl_next = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

`ifdef LOADER_CHECKSUM_EN
   logic       start_ok;
   logic [7:0] checksum;

   assign start_ok = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

   // Header and data bytes are folded in; the checksum byte itself is not
   loader_checksum u_checksum (
      .clk        (clk),
      .rst        (rst),
      .clr        (start_ok),
      .byte_valid (accept && (state != ST_CHECK)),
      .byte_data  (in_data),
      .sum        (checksum)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         in_ready     <= 1'b0;
         pm_we        <= 1'b0;
         pm_addr      <= '0;
         pm_wdata     <= 16'h0000;
         cpu_hold     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         len_hi       <= 8'h00;
         data_hi      <= 8'h00;
         len          <= 16'h0000;
      end else begin
         pm_we <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  state        <= ST_LEN_HI;
                  in_ready     <= 1'b1;
                  cpu_hold     <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= '0;
               end
            end
            ST_LEN_HI: begin
               if (accept) begin
                  len_hi <= in_data;
                  state  <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (accept) begin
                  len <= n_word;
                  if (32'(n_word) > DEPTH) begin
                     // Would overrun program memory: abort, keep the CPU held
                     state    <= ST_ERROR;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                  end else if (n_word == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                     state <= ST_CHECK;
`else
                     state    <= ST_DONE;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
`endif
                  end else begin
                     state <= ST_DATA_HI;
                  end
               end
            end
            ST_DATA_HI: begin
               if (accept) begin
                  data_hi <= in_data;
                  state   <= ST_DATA_LO;
               end
            end
            ST_DATA_LO: begin
               if (accept) begin
                  pm_we        <= 1'b1;
                  pm_wdata     <= {data_hi, in_data};
                  pm_addr      <= words_loaded[ADDR_W-1:0];
                  words_loaded <= wl_next;
                  if (32'(wl_next) == 32'(len)) begin
`ifdef LOADER_CHECKSUM_EN
                     state <= ST_CHECK;
`else
                     state    <= ST_DONE;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
`endif
                  end else begin
                     state <= ST_DATA_HI;
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (in_data == checksum) begin
                     state    <= ST_DONE;
                     cpu_hold <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     // Words already written stay in memory; CPU remains held
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader (scoreboard of expected writes)
module tb_prog_loader;
   import types_pkg::*;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              pm_we;
   logic [ADDR_W-1:0] pm_addr;
   logic [15:0]       pm_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   int n_tests = 0;
   int n_fail  = 0;
   int stalls  = 0;

   logic [31:0] exp_q[$];
   logic [15:0] mem [0:255];
   logic [15:0] img [0:7];

   always #5 clk = ~clk;

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .pm_we        (pm_we),
      .pm_addr      (pm_addr),
      .pm_wdata     (pm_wdata),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every pm_we pulse must match the oldest expected write
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst && pm_we === 1'b1) begin
         check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(pm_addr), {16'h0, e[31:16]});
            check("wr_data", 32'(pm_wdata), {16'h0, e[15:0]});
         end
         mem[pm_addr] = pm_wdata;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
      check({tag, "_pm_we"}, 32'(pm_we), 0);
      check({tag, "_pm_addr"}, 32'(pm_addr), 0);
      check({tag, "_pm_wdata"}, 32'(pm_wdata), 0);
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_error"}, 32'(error), 0);
      check({tag, "_words"}, 32'(words_loaded), 0);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Present one byte (optionally after a random idle gap) and return once it is accepted
   task automatic send_byte(input logic [7:0] b, input int max_gap, input bit poke);
      int gap;
      int waited;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int i = 0; i < gap; i++) begin
         in_valid = 1'b0;
         start    = poke && ($urandom_range(1, 0) == 1);
         @(posedge clk); #1;
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      check("in_ready", 32'(in_ready), 1);
      stalls += waited;
      @(posedge clk); #1;
   endtask

   task automatic build_bytes(input logic [15:0] w[$], output logic [7:0] bq[$]);
      logic [15:0] n;
      logic [7:0]  x;
      bq = {};
      n  = 16'(w.size());
      bq.push_back(n[15:8]);
      bq.push_back(n[7:0]);
      foreach (w[i]) begin
         bq.push_back(w[i][15:8]);
         bq.push_back(w[i][7:0]);
      end
      x = 8'h00;
      foreach (bq[i]) x ^= bq[i];
`ifdef LOADER_CHECKSUM_EN
      bq.push_back(x);
`endif
   endtask

   task automatic wait_not_busy();
      int k = 0;
      while (busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("finish_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
   endtask

   // Full successful load: expectations pushed before the bytes are driven
   task automatic load_words(input logic [15:0] w[$], input int max_gap, input bit poke);
      logic [7:0] bq[$];
      build_bytes(w, bq);
      foreach (w[i]) exp_q.push_back({16'(i), w[i]});
      stalls = 0;
      do_start();
      check("start_busy", 32'(busy), 1);
      check("start_hold", 32'(cpu_hold), 1);
      check("start_done_clr", 32'(done), 0);
      check("start_words_clr", 32'(words_loaded), 0);
      foreach (bq[i]) send_byte(bq[i], max_gap, poke);
      in_valid = 1'b0;
      wait_not_busy();
      if (max_gap == 0) check("no_bubbles", 32'(stalls), 0);
      check("end_done", 32'(done), 1);
      check("end_error", 32'(error), 0);
      check("end_hold", 32'(cpu_hold), 0);
      check("end_in_ready", 32'(in_ready), 0);
      check("end_words", 32'(words_loaded), 32'(w.size()));
      check("end_queue_empty", 32'(exp_q.size()), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] w[$];
      logic [7:0]  bq[$];
      logic [7:0]  x;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(posedge clk); #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Two-word load, back to back
      w = {16'h1234, 16'hABCD};
      load_words(w, 0, 0);

      // Count 257 exceeds 256-word memory: abort after the second byte, no writes
      do_start();
      send_byte(8'h01, 0, 0);
      send_byte(8'h01, 0, 0);
      in_valid = 1'b0;
      @(negedge clk);
      check("ovf_error", 32'(error), 1);
      check("ovf_busy", 32'(busy), 0);
      check("ovf_hold", 32'(cpu_hold), 1);
      check("ovf_in_ready", 32'(in_ready), 0);
      check("ovf_words", 32'(words_loaded), 0);
      repeat (5) @(negedge clk);
      check("ovf_error_sticky", 32'(error), 1);

      // Zero-length load (leaves ERROR via start)
      w = {};
      load_words(w, 0, 0);

      // Full depth: every address exactly once, no wrap
      w = {};
      for (int i = 0; i < 256; i++) w.push_back(16'((i * 16'h0101) ^ 16'h5A3C));
      load_words(w, 0, 0);

      // Reset after 3 of 5 words abandons the load
      w = {};
      for (int i = 0; i < 5; i++) w.push_back(16'($urandom));
      build_bytes(w, bq);
      for (int i = 0; i < 3; i++) exp_q.push_back({16'(i), w[i]});
      do_start();
      for (int i = 0; i < int'(HDR_LEN) + 6; i++) send_byte(bq[i], 0, 0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_three_written", 32'(exp_q.size()), 0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("midrst_idle_busy", 32'(busy), 0);
      @(posedge clk); #1;
      load_words(w, 0, 0);

      // Random valid gaps and stray starts must give the same memory image
      w = {};
      for (int i = 0; i < 8; i++) w.push_back(16'($urandom));
      load_words(w, 0, 0);
      for (int i = 0; i < 8; i++) img[i] = mem[i];
      for (int i = 0; i < 256; i++) mem[i] = 16'hxxxx;
      load_words(w, 3, 1);
      for (int i = 0; i < 8; i++) check("image_match", 32'(mem[i]), 32'(img[i]));

`ifdef LOADER_CHECKSUM_EN
      // Wrong checksum: error, CPU held, the written word stays
      w = {16'h1234};
      build_bytes(w, bq);
      x = bq[bq.size() - 1] ^ 8'h01;
      bq[bq.size() - 1] = x;
      exp_q.push_back({16'h0000, 16'h1234});
      do_start();
      foreach (bq[i]) send_byte(bq[i], 0, 0);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("badck_error", 32'(error), 1);
      check("badck_hold", 32'(cpu_hold), 1);
      check("badck_done", 32'(done), 0);
      check("badck_words", 32'(words_loaded), 1);
      check("badck_queue", 32'(exp_q.size()), 0);
      @(posedge clk); #1;
      load_words(w, 0, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
